// File: rtl/mips_multi_cycle_control.sv
// rtl/mips_multi_cycle_control.sv - main control FSM for the multi-cycle MIPS datapath
// Moore outputs decoded from the state register; only PCEn mixes in the ALU zero flag.
module mips_multi_cycle_control #(
   parameter int STATE_W = 4,
   parameter int ALUCW   = 3
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [5:0]         opcode,
   input  logic [5:0]         funct,
   input  logic               zero,
   output logic               PCEn,
   output logic               IorD,
   output logic               MemWrite,
   output logic               IRWrite,
   output logic               RegDst,
   output logic               MemtoReg,
   output logic               RegWrite,
   output logic               ALUSrcA,
   output logic [1:0]         ALUSrcB,
   output logic [ALUCW-1:0]   ALUControl,
   output logic [1:0]         PCSrc,
   output logic [STATE_W-1:0] state_o,
   output logic               illegal_o
);

   typedef enum logic [STATE_W-1:0] {
      S_FETCH    = STATE_W'(0),
      S_DECODE   = STATE_W'(1),
      S_MEMADR   = STATE_W'(2),
      S_MEMRD    = STATE_W'(3),
      S_MEMWB    = STATE_W'(4),
      S_MEMWR    = STATE_W'(5),
      S_EXECUTE  = STATE_W'(6),
      S_ALUWB    = STATE_W'(7),
      S_BRANCH   = STATE_W'(8),
      S_ADDIEXEC = STATE_W'(9),
      S_ADDIWB   = STATE_W'(10),
      S_JUMP     = STATE_W'(11)
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;

   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_SLT = 6'b101010;

   localparam logic [ALUCW-1:0] ALU_ADD = ALUCW'(3'b010);
   localparam logic [ALUCW-1:0] ALU_SUB = ALUCW'(3'b110);
   localparam logic [ALUCW-1:0] ALU_AND = ALUCW'(3'b000);
   localparam logic [ALUCW-1:0] ALU_OR  = ALUCW'(3'b001);
   localparam logic [ALUCW-1:0] ALU_SLT = ALUCW'(3'b111);

   state_t state_q;
   state_t state_d;
   state_t dec_state;

   logic             pc_write;
   logic             branch;
   logic             mem_write_raw;
   logic             ir_write_raw;
   logic             reg_write_raw;
   logic             illegal_raw;
   logic             iord_c;
   logic             reg_dst_c;
   logic             mem_to_reg_c;
   logic             alu_src_a_c;
   logic [1:0]       alu_src_b_c;
   logic [ALUCW-1:0] alu_control_c;
   logic [1:0]       pc_src_c;

   always_comb begin
      state_d = S_FETCH;
      case (state_q)
         S_FETCH:  state_d = S_DECODE;
         S_DECODE: begin
            case (opcode)
               OP_LW, OP_SW: state_d = S_MEMADR;
               OP_RTYPE:     state_d = S_EXECUTE;
               OP_BEQ:       state_d = S_BRANCH;
               OP_ADDI:      state_d = S_ADDIEXEC;
               OP_J:         state_d = S_JUMP;
               default:      state_d = S_FETCH;
            endcase
         end
         S_MEMADR:   state_d = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
         S_MEMRD:    state_d = S_MEMWB;
         S_EXECUTE:  state_d = S_ALUWB;
         S_ADDIEXEC: state_d = S_ADDIWB;
         default:    state_d = S_FETCH;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_FETCH;
      end else begin
         state_q <= state_d;
      end
   end

   // Outputs show FETCH values while reset is held so the datapath sees a clean first fetch.
   assign dec_state = reset ? S_FETCH : state_q;

   always_comb begin
      pc_write      = 1'b0;
      branch        = 1'b0;
      mem_write_raw = 1'b0;
      ir_write_raw  = 1'b0;
      reg_write_raw = 1'b0;
      illegal_raw   = 1'b0;
      iord_c        = 1'b0;
      reg_dst_c     = 1'b0;
      mem_to_reg_c  = 1'b0;
      alu_src_a_c   = 1'b0;
      alu_src_b_c   = 2'b00;
      alu_control_c = ALU_ADD;
      pc_src_c      = 2'b00;
      case (dec_state)
         S_FETCH: begin
            alu_src_b_c  = 2'b01;
            ir_write_raw = 1'b1;
            pc_write     = 1'b1;
         end
         S_DECODE: begin
            alu_src_b_c = 2'b11;
            case (opcode)
               OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI, OP_J: illegal_raw = 1'b0;
               default:                                       illegal_raw = 1'b1;
            endcase
         end
         S_MEMADR: begin
            alu_src_a_c = 1'b1;
            alu_src_b_c = 2'b10;
         end
         S_MEMRD: iord_c = 1'b1;
         S_MEMWB: begin
            mem_to_reg_c  = 1'b1;
            reg_write_raw = 1'b1;
         end
         S_MEMWR: begin
            iord_c        = 1'b1;
            mem_write_raw = 1'b1;
         end
         S_EXECUTE: begin
            alu_src_a_c = 1'b1;
            case (funct)
               FN_ADD:  alu_control_c = ALU_ADD;
               FN_SUB:  alu_control_c = ALU_SUB;
               FN_AND:  alu_control_c = ALU_AND;
               FN_OR:   alu_control_c = ALU_OR;
               FN_SLT:  alu_control_c = ALU_SLT;
               default: illegal_raw   = 1'b1;
            endcase
         end
         S_ALUWB: begin
            reg_dst_c     = 1'b1;
            reg_write_raw = 1'b1;
         end
         S_BRANCH: begin
            alu_src_a_c   = 1'b1;
            alu_control_c = ALU_SUB;
            pc_src_c      = 2'b01;
            branch        = 1'b1;
         end
         S_ADDIEXEC: begin
            alu_src_a_c = 1'b1;
            alu_src_b_c = 2'b10;
         end
         S_ADDIWB: reg_write_raw = 1'b1;
         S_JUMP: begin
            pc_src_c = 2'b10;
            pc_write = 1'b1;
         end
         default: ;
      endcase
   end

   assign PCEn       = ~reset & (pc_write | (branch & zero));
   assign MemWrite   = ~reset & mem_write_raw;
   assign IRWrite    = ~reset & ir_write_raw;
   assign RegWrite   = ~reset & reg_write_raw;
   assign illegal_o  = ~reset & illegal_raw;
   assign IorD       = iord_c;
   assign RegDst     = reg_dst_c;
   assign MemtoReg   = mem_to_reg_c;
   assign ALUSrcA    = alu_src_a_c;
   assign ALUSrcB    = alu_src_b_c;
   assign ALUControl = alu_control_c;
   assign PCSrc      = pc_src_c;
   assign state_o    = state_q;

   a_single_write: assert property (@(posedge clk) disable iff (reset)
      $onehot0({MemWrite, RegWrite, IRWrite}));

endmodule
